mul_issue_ctrl: RTL and testbench

Execute-stage controller that sits directly upstream of the iterative 32x32 multiplier and also consumes its result.
- Accepts MULT/MULTU/MUL operations from the EX stage and latches the operands.
- Drives the multiplier's start/annul handshake and raises a pipeline stall request until the product returns.
- Writes the 64-bit product into the architectural HI/LO registers, or returns the low word to the GPR writeback path.
- Also owns MTHI/MTLO writes and HI/LO read-out.

---
 rtl/mul_issue_ctrl_if.sv | 22 ++
 rtl/mul_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_ctrl_if.sv
// rtl/mul_issue_ctrl_if.sv - start/annul/result handshake between the issue controller and the iterative multiplier
interface mul_issue_ctrl_if;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic        mul_signed_o;
  logic        mul_start_o;
  logic        mul_annul_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;

  // Controller side: drives operands and handshake, consumes the product
  modport master (
    output mul_op1_o, mul_op2_o, mul_signed_o, mul_start_o, mul_annul_o,
    input  mul_result_i, mul_ready_i
  );

  // Multiplier side
  modport slave (
    input  mul_op1_o, mul_op2_o, mul_signed_o, mul_start_o, mul_annul_o,
    output mul_result_i, mul_ready_i
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - EX-stage multiply issue/stall controller with HI/LO registers; optional MUL_ZERO_BYPASS_EN
module mul_issue_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        flush_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  mul_issue_ctrl_if.master mul,
  output logic        stall_req_o,
  output logic        gpr_we_o,
  output logic [31:0] gpr_wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        signed_q, signed_d;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        zero_opnd;
  logic        stall;
  logic        gpr_we;
  logic [31:0] gpr_wdata;

  assign accept = op_valid_i & (op_i != OP_NONE) & ~flush_i;

`ifdef MUL_ZERO_BYPASS_EN
  // A zero operand makes the product trivially zero, so skip the multiplier
  assign zero_opnd = (opdata1_i == 32'd0) | (opdata2_i == 32'd0);
`else
  assign zero_opnd = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= OP_NONE;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      signed_q <= 1'b0;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state, handshake, HI/LO update and combinational stall/writeback
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    signed_d  = signed_q;
    start_d   = start_q;
    annul_d   = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall     = 1'b0;
    gpr_we    = 1'b0;
    gpr_wdata = mul.mul_result_i[31:0];

    case (state_q)
      IDLE: begin
        if (accept && zero_opnd) begin
          if (op_i == OP_MUL) begin
            gpr_we    = 1'b1;
            gpr_wdata = 32'd0;
          end else begin
            hi_d = 32'd0;
            lo_d = 32'd0;
          end
        end else if (accept) begin
          stall    = 1'b1;
          op_d     = op_i;
          op1_d    = opdata1_i;
          op2_d    = opdata2_i;
          signed_d = (op_i != OP_MULTU);
          start_d  = 1'b1;
          state_d  = BUSY;
        end else if (!flush_i) begin
          if (mthi_i) hi_d = wdata_i;
          if (mtlo_i) lo_d = wdata_i;
        end
      end

      BUSY: begin
        stall = ~mul.mul_ready_i | flush_i;
        // Flush takes priority so a product arriving in the same cycle is dropped
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          state_d = DRAIN;
        end else if (mul.mul_ready_i) begin
          if (op_q == OP_MUL) begin
            gpr_we = 1'b1;
          end else begin
            hi_d = mul.mul_result_i[63:32];
            lo_d = mul.mul_result_i[31:0];
          end
          start_d = 1'b0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Wait for the multiplier to drop ready so a stale result is never reused
        stall = op_valid_i & (op_i != OP_NONE);
        if (!mul.mul_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mul.mul_op1_o    = op1_q;
  assign mul.mul_op2_o    = op2_q;
  assign mul.mul_signed_o = signed_q;
  assign mul.mul_start_o  = start_q;
  assign mul.mul_annul_o  = annul_q;

  assign stall_req_o = stall;
  assign gpr_we_o    = gpr_we;
  assign gpr_wdata_o = gpr_wdata;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - self-checking bench for mul_issue_ctrl with an iterative multiplier stub
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        flush_i = 1'b0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        stall_req_o;
  logic        gpr_we_o;
  logic [31:0] gpr_wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  always #5 clk = ~clk;

  mul_issue_ctrl_if mif();

  mul_issue_ctrl dut (
    .clk(clk), .resetn(resetn),
    .op_valid_i(op_valid_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .flush_i(flush_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i),
    .mul(mif),
    .stall_req_o(stall_req_o), .gpr_we_o(gpr_we_o), .gpr_wdata_o(gpr_wdata_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // Multiplier stub: ready rises 35 cycles after start is first seen, falls once start drops
  logic        sb_busy, sb_done;
  logic [5:0]  sb_cnt;
  logic [63:0] sb_res;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_busy <= 1'b0; sb_done <= 1'b0; sb_cnt <= '0; sb_res <= '0;
    end else if (mif.mul_annul_o || !mif.mul_start_o) begin
      sb_busy <= 1'b0; sb_done <= 1'b0;
    end else if (!sb_busy && !sb_done) begin
      sb_busy <= 1'b1; sb_cnt <= 6'd1;
    end else if (sb_busy) begin
      sb_cnt <= sb_cnt + 6'd1;
      if (sb_cnt == 6'd34) begin
        sb_busy <= 1'b0;
        sb_done <= 1'b1;
        sb_res  <= mif.mul_signed_o
                 ? 64'($signed({{32{mif.mul_op1_o[31]}}, mif.mul_op1_o}) * $signed({{32{mif.mul_op2_o[31]}}, mif.mul_op2_o}))
                 : ({32'd0, mif.mul_op1_o} * {32'd0, mif.mul_op2_o});
      end
    end
  end
  assign mif.mul_result_i = sb_res;
  assign mif.mul_ready_i  = sb_done;

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  int r_stall_cnt, r_stall_last, r_gpr_cnt, r_gpr_cyc, r_start_cnt, r_annul_cnt, r_annul_cyc;
  logic [31:0] r_gpr_val, r_hi36, r_lo36, r_hi37, r_lo37;
  logic r_signed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product from the op code alone, using plain 64-bit integer arithmetic
  function automatic logic [63:0] model_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    if (op == 2'b10) begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end else begin
      x = longint'(int'(a));
      y = longint'(int'(b));
    end
    return 64'(x * y);
  endfunction

  // Issue one op at cycle 0 and observe 40 cycles; optional flush / MTLO injection cycles
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int mtlo_at, input logic [31:0] mtdata);
    r_stall_cnt = 0; r_stall_last = -1; r_gpr_cnt = 0; r_gpr_cyc = -1; r_gpr_val = '0;
    r_start_cnt = 0; r_annul_cnt = 0; r_annul_cyc = -1; r_signed = 1'b0;
    r_hi36 = '0; r_lo36 = '0; r_hi37 = '0; r_lo37 = '0;
    for (int k = 0; k < 40; k++) begin
      op_valid_i = (k == 0);
      op_i       = (k == 0) ? op : 2'b00;
      opdata1_i  = a;
      opdata2_i  = b;
      flush_i    = (k == flush_at);
      mtlo_i     = (k == mtlo_at);
      wdata_i    = mtdata;
      #1;
      if (stall_req_o) begin r_stall_cnt++; r_stall_last = k; end
      if (gpr_we_o) begin r_gpr_cnt++; r_gpr_cyc = k; r_gpr_val = gpr_wdata_o; end
      if (mif.mul_start_o) r_start_cnt++;
      if (mif.mul_annul_o) begin r_annul_cnt++; r_annul_cyc = k; end
      if (k == 1) r_signed = mif.mul_signed_o;
      if (k == 36) begin r_hi36 = hi_o; r_lo36 = lo_o; end
      if (k == 37) begin r_hi37 = hi_o; r_lo37 = lo_o; end
      @(posedge clk); #2;
    end
    op_valid_i = 1'b0; op_i = 2'b00; flush_i = 1'b0; mtlo_i = 1'b0;
  endtask

  // One-cycle MTHI/MTLO in IDLE; caller has already updated m_hi/m_lo
  task automatic do_mt(input logic h, input logic l, input logic [31:0] d);
    mthi_i = h; mtlo_i = l; wdata_i = d;
    #1;
    chk("mt_stall", {63'd0, stall_req_o}, 64'd0);
    @(posedge clk); #2;
    mthi_i = 1'b0; mtlo_i = 1'b0;
    #1;
    chk("mt_hi", {32'd0, hi_o}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, lo_o}, {32'd0, m_lo});
    @(posedge clk); #2;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_gpr_we;
    logic [31:0] exp_gpr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit byp;
    int prev_start, restart, st37, st38;
    logic [63:0] p;
    logic [1:0] op;
    logic [31:0] a, b, d;
    int kind;

    tbl[0] = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 32'h0};
    tbl[1] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32'h0};
    tbl[2] = '{2'b11, 32'h00001234, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 32'hFFFFEDCC};
    tbl[3] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32'h0};
    tbl[4] = '{2'b10, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 32'h0};
    tbl[5] = '{2'b01, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h0};
    tbl[6] = '{2'b11, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h0};
    tbl[7] = '{2'b01, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_stall", {63'd0, stall_req_o}, 64'd0);
    chk("rst_start", {63'd0, mif.mul_start_o}, 64'd0);
    chk("rst_annul", {63'd0, mif.mul_annul_o}, 64'd0);
    chk("rst_ops", {mif.mul_op1_o, mif.mul_op2_o}, 64'd0);
    chk("rst_signed", {63'd0, mif.mul_signed_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #2;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      byp = BYP && (tbl[i].a == 0 || tbl[i].b == 0);
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, -1, -1, 32'd0);
      chk($sformatf("t%0d_stall_cnt", i), 64'(r_stall_cnt), byp ? 64'd0 : 64'd36);
      chk($sformatf("t%0d_start_cnt", i), 64'(r_start_cnt), byp ? 64'd0 : 64'd36);
      chk($sformatf("t%0d_gpr_cnt", i), 64'(r_gpr_cnt), {63'd0, tbl[i].exp_gpr_we});
      if (tbl[i].exp_gpr_we) begin
        chk($sformatf("t%0d_gpr_cyc", i), 64'(r_gpr_cyc), byp ? 64'd0 : 64'd36);
        chk($sformatf("t%0d_gpr_val", i), {32'd0, r_gpr_val}, {32'd0, tbl[i].exp_gpr});
      end
      if (!byp) begin
        chk($sformatf("t%0d_signed", i), {63'd0, r_signed}, {63'd0, tbl[i].op != 2'b10});
        chk($sformatf("t%0d_stall_last", i), 64'(r_stall_last), 64'd35);
      end
      if (!byp && tbl[i].op != 2'b11) begin
        chk($sformatf("t%0d_hilo36", i), {r_hi36, r_lo36}, {m_hi, m_lo});
        chk($sformatf("t%0d_hilo37", i), {r_hi37, r_lo37}, {tbl[i].exp_hi, tbl[i].exp_lo});
      end
      chk($sformatf("t%0d_hilo", i), {hi_o, lo_o}, {tbl[i].exp_hi, tbl[i].exp_lo});
      m_hi = tbl[i].exp_hi;
      m_lo = tbl[i].exp_lo;
    end

    // MTHI in IDLE
    m_hi = 32'hDEADBEEF;
    do_mt(1'b1, 1'b0, 32'hDEADBEEF);

    // MULT 7x9 flushed in cycle 10
    run_op(2'b01, 32'd7, 32'd9, 10, -1, 32'd0);
    chk("fl_annul_cnt", 64'(r_annul_cnt), 64'd1);
    chk("fl_annul_cyc", 64'(r_annul_cyc), 64'd11);
    chk("fl_stall_last", 64'(r_stall_last), 64'd10);
    chk("fl_gpr_cnt", 64'(r_gpr_cnt), 64'd0);
    chk("fl_hilo", {hi_o, lo_o}, {m_hi, m_lo});

    // MULT 2x3 with an MTLO presented while BUSY: the MTLO must be dropped
    run_op(2'b01, 32'd2, 32'd3, -1, 5, 32'h00000055);
    m_hi = 32'd0; m_lo = 32'd6;
    chk("busy_mt_hilo", {hi_o, lo_o}, 64'd6);
    m_lo = 32'h00000055;
    do_mt(1'b0, 1'b1, 32'h00000055);

    // Back-to-back: second op held presented; restart only after ready falls
    prev_start = 0; restart = -1; st37 = 0; st38 = 0;
    for (int k = 0; k < 86; k++) begin
      op_valid_i = (k <= 39);
      op_i       = (k <= 39) ? 2'b01 : 2'b00;
      opdata1_i  = (k == 0) ? 32'd2 : 32'd4;
      opdata2_i  = (k == 0) ? 32'd3 : 32'd5;
      #1;
      if (k == 37) st37 = int'(stall_req_o);
      if (k == 38) st38 = int'(stall_req_o);
      if (mif.mul_start_o && prev_start == 0 && k > 1 && restart < 0) restart = k;
      prev_start = int'(mif.mul_start_o);
      @(posedge clk); #2;
    end
    op_valid_i = 1'b0; op_i = 2'b00;
    chk("b2b_restart", 64'(restart), 64'd40);
    chk("b2b_stall_drain", 64'(st37 + st38), 64'd2);
    m_hi = 32'd0; m_lo = 32'd20;
    chk("b2b_hilo", {hi_o, lo_o}, {m_hi, m_lo});

    // Randomized ops against the arithmetic model
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 5);
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      d = $urandom();
      if (kind <= 2) begin
        op = (kind == 0) ? 2'b01 : (kind == 1) ? 2'b10 : 2'b11;
        byp = BYP && (a == 0 || b == 0);
        p = model_prod(op, a, b);
        run_op(op, a, b, -1, -1, 32'd0);
        chk($sformatf("r%0d_stall", n), 64'(r_stall_cnt), byp ? 64'd0 : 64'd36);
        chk($sformatf("r%0d_gpr_cnt", n), 64'(r_gpr_cnt), (op == 2'b11) ? 64'd1 : 64'd0);
        if (op == 2'b11) chk($sformatf("r%0d_gpr_val", n), {32'd0, r_gpr_val}, {32'd0, p[31:0]});
        else begin m_hi = p[63:32]; m_lo = p[31:0]; end
        chk($sformatf("r%0d_hilo", n), {hi_o, lo_o}, {m_hi, m_lo});
      end else begin
        if (kind != 4) m_hi = d;
        if (kind != 3) m_lo = d;
        do_mt(kind != 4, kind != 3, d);
      end
    end

    // Reset in the middle of an operation
    m_hi = 32'h12345678; m_lo = 32'h12345678;
    do_mt(1'b1, 1'b1, 32'h12345678);
    op_valid_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd3; opdata2_i = 32'd3;
    @(posedge clk); #2;
    op_valid_i = 1'b0; op_i = 2'b00;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_stall", {63'd0, stall_req_o}, 64'd0);
    chk("mid_rst_start", {63'd0, mif.mul_start_o}, 64'd0);
    chk("mid_rst_ops", {mif.mul_op1_o, mif.mul_op2_o}, 64'd0);
    chk("mid_rst_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #2;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    run_op(2'b01, 32'd2, 32'd3, -1, -1, 32'd0);
    chk("post_rst_hilo", {hi_o, lo_o}, 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
